// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared widths and constants for the instruction fetch stage, the layout of
//   one fetch-queue entry, and a word-alignment helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   // PC advance per fetched word and the architectural PC read offset (ARM).
   localparam logic [ADDR_W-1:0] PC_STEP        = 32'd4;
   localparam logic [ADDR_W-1:0] PC_READ_OFFSET = 32'd8;

   // One queue entry: the fetched word tagged with the byte address it came from.
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   localparam int QWIDTH = $bits(fetch_entry_t);

   // Forces a byte address onto a word boundary.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Synchronous FIFO with registered storage used to buffer fetched words.
//   flush empties the queue and has priority over push and pop.
//   A push while full is accepted only when a pop happens in the same cycle.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high; empties the queue
//   flush_i  in   1      discard all entries this cycle
//   push_i   in   1      write wdata_i at the tail
//   pop_i    in   1      remove the head entry
//   wdata_i  in   WIDTH  data to enqueue
//   full_o   out  1      DEPTH entries held
//   empty_o  out  1      no entries held
//   head_o   out  WIDTH  entry at the head (meaningful only when !empty_o)
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q,  count_d;

   logic push_ok;
   logic pop_ok;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full queue only fits if the head leaves in the same cycle.
   assign push_ok = push_i & (~full_o | pop_i);
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (!reset && !flush_i && push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the PC, drives the combinational-read
//   instruction memory, buffers returned words in fetch_queue and presents
//   them to decode over a valid/ready handshake. A branch redirect flushes
//   the queue and reloads the PC.
//
//   Handshake: an instruction transfers on a cycle where out_valid and
//   out_ready are both high; while out_valid is high and out_ready low, the
//   head (out_instr/out_pc/out_pc8) holds stable.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high
//   imem_addr    out  32  byte address to instruction memory (= pc)
//   imem_rd      in   32  word read combinationally at imem_addr
//   redirect     in   1   branch taken: flush and load redirect_pc
//   redirect_pc  in   32  branch target byte address (low bits ignored)
//   out_valid    out  1   queue head holds a valid instruction
//   out_ready    in   1   decode accepts the head this cycle
//   out_instr    out  32  instruction at the queue head (0 when empty)
//   out_pc       out  32  byte address of out_instr (0 when empty)
//   out_pc8      out  32  out_pc + 8
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rd,
   input  logic              redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [ADDR_W-1:0]  out_pc8
);

   logic [ADDR_W-1:0] pc_q, pc_d;

   logic         q_full;
   logic         q_empty;
   logic         push;
   logic         pop;
   fetch_entry_t wr_entry;
   fetch_entry_t head;

   assign imem_addr = pc_q;
   assign out_valid = ~q_empty;

   // A redirect suppresses the push and the queue flush discards the pop, so
   // neither the wrong-path word nor the head transfer survives the cycle.
   assign pop  = out_valid & out_ready;
   assign push = ~redirect & (~q_full | pop);

   assign wr_entry = '{pc: pc_q, instr: imem_rd};

   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = word_align(redirect_pc);
      end else if (push) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   // Reset is checked first so it also cancels a redirect in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= word_align(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_queue #(
      .WIDTH (QWIDTH),
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .reset   (reset),
      .flush_i (redirect),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .full_o  (q_full),
      .empty_o (q_empty),
      .head_o  (head)
   );

   // Gate the head with empty so stale storage never leaks onto the outputs.
   assign out_instr = q_empty ? '0 : head.instr;
   assign out_pc    = q_empty ? '0 : head.pc;
   assign out_pc8   = out_pc + PC_READ_OFFSET;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed and randomised checks of fetch_unit. A queue-based model of the
//   fetch stream predicts every presented word; literal tables pin the model.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int          QDEPTH    = 4;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;

   localparam logic [31:0] INSTR_TBL [4] = '{32'hE3A00000, 32'hE3A01001, 32'hE3A02002, 32'hE3A04003};
   localparam logic [31:0] ADDR_TBL  [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
   localparam logic [31:0] PC8_TBL   [4] = '{32'h8, 32'hC, 32'h10, 32'h14};
   localparam logic [31:0] WRAP_TBL  [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

   // ---------------- clock / reset / signals ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_ready = 1'b1;

   logic [31:0] imem_addr, imem_rd, out_instr, out_pc, out_pc8;
   logic        out_valid;

   logic [31:0] imem_addr2, imem_rd2, out_instr2, out_pc2, out_pc8_2;
   logic        out_valid2;
   logic        redirect2 = 1'b0;
   logic [31:0] redirect_pc2 = '0;
   logic        out_ready2 = 1'b1;

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instruction memory contents: the first four words are the program,
   // everything else is a distinct value derived from the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'hE3A00000;
         32'h4:   return 32'hE3A01001;
         32'h8:   return 32'hE3A02002;
         32'hC:   return 32'hE3A04003;
         default: return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
      endcase
   endfunction

   assign imem_rd  = mem_word(imem_addr);
   assign imem_rd2 = mem_word(imem_addr2);

   fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_rd     (imem_rd),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_pc8     (out_pc8)
   );

   fetch_unit #(.RESET_PC(RESET_PC2), .QDEPTH(QDEPTH)) dut_wrap (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr2),
      .imem_rd     (imem_rd2),
      .redirect    (redirect2),
      .redirect_pc (redirect_pc2),
      .out_valid   (out_valid2),
      .out_ready   (out_ready2),
      .out_instr   (out_instr2),
      .out_pc      (out_pc2),
      .out_pc8     (out_pc8_2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model / scoreboard ----------------
   // exp_q holds the byte addresses of words the stage must present, in
   // order; model_pc is the next address to be fetched.
   logic [31:0] exp_q[$];
   logic [31:0] model_pc = RESET_PC;

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            exp_q.delete();
            model_pc = RESET_PC;
         end else if (redirect) begin
            exp_q.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
         end else begin
            automatic bit take = (exp_q.size() > 0) && out_ready;
            automatic bit room = (exp_q.size() < QDEPTH) || take;
            if (take) void'(exp_q.pop_front());
            if (room) begin
               exp_q.push_back(model_pc);
               model_pc = model_pc + 32'd4;
            end
         end
      end
   end

   // Compare process: every cycle outside reset, mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("m_addr", imem_addr, model_pc);
            chk("m_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
               chk("m_pc", out_pc, exp_q[0]);
               chk("m_instr", out_instr, mem_word(exp_q[0]));
               chk("m_pc8", out_pc8, exp_q[0] + 32'd8);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic ready);
      tick();
      reset = 1'b1;
      redirect = 1'b0;
      out_ready = ready;
      tick();
      reset = 1'b0;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_pc8", out_pc8, 32'd8);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);

      // Straight-line fetch with out_ready=1, plus the wrapping instance.
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) begin
            chk("seq_addr", imem_addr, ADDR_TBL[i]);
            chk("wrap_addr", imem_addr2, WRAP_TBL[i]);
         end
         if (i >= 1) begin
            chk("seq_valid", {31'b0, out_valid}, 32'd1);
            chk("seq_instr", out_instr, INSTR_TBL[i-1]);
            chk("seq_pc8", out_pc8, PC8_TBL[i-1]);
         end
         if (i == 1) chk("wrap_pc8", out_pc8_2, 32'h0);
      end

      // Stall for 10 cycles from reset: queue fills, PC parks at 4*QDEPTH.
      do_reset(1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_head", out_pc, 32'h0);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("drain_valid", {31'b0, out_valid}, 32'd1);
         chk("drain_pc", out_pc, 32'(4 * i));
      end

      // Redirect to an unaligned target while the queue is full and stalled.
      tick();
      out_ready = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0007;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      chk("redir_valid", {31'b0, out_valid}, 32'd0);
      chk("redir_addr", imem_addr, 32'h4);
      @(negedge clk);
      chk("redir_valid2", {31'b0, out_valid}, 32'd1);
      chk("redir_pc", out_pc, 32'h4);

      // Reset and redirect together with three words queued.
      do_reset(1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      reset = 1'b0;
      redirect = 1'b0;
      @(negedge clk);
      chk("rr_valid", {31'b0, out_valid}, 32'd0);
      chk("rr_addr", imem_addr, RESET_PC);
      @(negedge clk);
      chk("rr_pc", out_pc, RESET_PC);

      // Random ready with periodic and back-to-back redirects.
      for (int i = 0; i < 300; i++) begin
         tick();
         out_ready = 1'($urandom_range(0, 1));
         redirect = ((i % 9) == 8) || ((i % 40) == 20) || ((i % 40) == 21);
         redirect_pc = 32'($urandom_range(0, 255));
      end
      tick();
      redirect = 1'b0;
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fetch_unit
